uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16: FIFO entries; power of two, 2..256.
REQ-002 The block SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port write_data, input, 8 bits: byte to enqueue.
REQ-005 The block SHALL have port write_enable, input, 1 bit: enqueue request, sampled each clock.
REQ-006 The block SHALL have port full, output, 1 bit: high when count == DEPTH.
REQ-007 The block SHALL have port empty, output, 1 bit: high when count == 0.
REQ-008 The block SHALL have port count, output, clog2(DEPTH)+1 bits: current number of stored entries.
REQ-009 The block SHALL have port tx_data, output, 8 bits: byte presented to the transmitter's data input.
REQ-010 The block SHALL have port tx_enable, output, 1 bit: drives the transmitter's enable input.
REQ-011 The block SHALL have port tx_done, input, 1 bit: transmitter done; may be asynchronous to clock (baud-clock domain).
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL pass tx_done through a 2-flop synchronizer; only the synchronized value (done_s) is used internally.
REQ-014 The block SHALL store write_data at the write pointer and increment the write pointer when write_enable=1 and full=0; the write pointer wraps DEPTH-1 -> 0.
REQ-015 The block SHALL drop write_enable while full=1, even if a pop occurs in the same cycle; count and pointers stay unchanged by the dropped write.
REQ-016 The block SHALL implement the FSM states IDLE, SEND and RELEASE.
REQ-017 In IDLE with empty=0 and done_s=0, the block SHALL register mem[read pointer] into tx_data, increment the read pointer with wrap, assert tx_enable and move to SEND, all on one edge.
REQ-018 In IDLE with empty=1, or with done_s=1, the block SHALL remain in IDLE with tx_enable=0.
REQ-019 In SEND, the block SHALL hold tx_data and tx_enable=1 stable until done_s=1, then deassert tx_enable and move to RELEASE.
REQ-020 In RELEASE, the block SHALL wait for done_s=0, then return to IDLE; this guarantees one enable pulse per byte.
REQ-021 When push and pop occur in the same cycle, the block SHALL leave count unchanged and advance both pointers.
REQ-022 The block SHALL update count, full and empty on the same edge that changes the pointers.
REQ-023 Latency from a write into an empty, idle queue to tx_enable=1 SHALL be 2 clocks: the write edge plus the pop edge.
REQ-024 The block SHALL never assert tx_enable while empty=1 in IDLE, and SHALL never underflow the queue.
REQ-025 The block SHALL not modify tx_data except on the IDLE->SEND transition.

Reset
REQ-026 On reset=1, the block SHALL immediately clear all of the following, without waiting for a clock:
- read/write pointers, count=0, empty=1, full=0;
- tx_enable=0, tx_data=8'h00, FSM=IDLE, busy=0;
- both synchronizer flops.
REQ-027 Reset asserted in the middle of a transfer SHALL abort it: tx_enable drops asynchronously and the queued data is discarded. FIFO memory contents need not be cleared.

Configuration
REQ-028 With macro UART_TX_QUEUE_OVERFLOW_FLAG_EN defined, the block SHALL add output overflow, 1 bit:
- set sticky on any write_enable while full=1;
- cleared only by reset (reset value 0).
REQ-029 Without UART_TX_QUEUE_OVERFLOW_FLAG_EN, the port overflow and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Single byte: write 8'hAB into an empty queue -> tx_enable=1 with tx_data=8'hAB two clocks later; after the tx_done pulse, tx_enable=0, the FSM is back in IDLE, and empty=1.
REQ-031 Burst: write 8'h01..8'h10 (DEPTH=16) back-to-back while tx_done stays low -> after the first pop, count peaks at 15 and full never asserts.
REQ-032 Ordering: the bench models the transmitter by echoing done 3 clocks after enable, holding it for 2 clocks, and collecting bytes -> the bytes are received as 8'h01..8'h10 in order, with exactly one enable pulse each.
REQ-033 Overflow: fill 16 bytes while stalled, then write 8'hFF -> count stays 16 and 8'hFF is never transmitted; with the macro, overflow=1 until reset.
REQ-034 Wrap-around: push and pop 40 bytes with simultaneous write and pop -> the data stays correct across pointer wrap and count never exceeds DEPTH.
REQ-035 Reset mid-SEND: assert reset while tx_enable=1 -> tx_enable=0 and count=0 before the next clock edge; after release, an idle queue produces no further tx_enable.

Source files
------------

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Purpose  : Byte FIFO feeding a UART transmitter, one enable pulse per byte,
//            with a 2-flop synchronizer on the transmitter's done signal.
// Options  : define UART_TX_QUEUE_OVERFLOW_FLAG_EN for a sticky overflow output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int DEPTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              write_data,
    input  logic                    write_enable,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [7:0]              tx_data,
    output logic                    tx_enable,
    input  logic                    tx_done,
    output logic                    busy
`ifdef UART_TX_QUEUE_OVERFLOW_FLAG_EN
    ,
    output logic                    overflow
`endif
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   c_DEPTH = CW'(DEPTH);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SEND    = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_tx_data;
    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_sync_q1;
    logic          r_done_s;
    logic          w_push;
    logic          w_pop;

    assign full  = (r_count == c_DEPTH);
    assign empty = (r_count == '0);
    assign count = r_count;

    // A write while full is dropped outright, even when a pop frees a slot.
    assign w_push = write_enable && !full;
    assign w_pop  = (r_state == c_IDLE) && !empty && !r_done_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync_q1 <= 1'b0;
            r_done_s  <= 1'b0;
        end else begin
            r_sync_q1 <= tx_done;
            r_done_s  <= r_sync_q1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tx_data <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_tx_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // RELEASE waits for done to fall so a long done level cannot start a second byte.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:    if (w_pop)     w_state_next = c_SEND;
            c_SEND:    if (r_done_s)  w_state_next = c_RELEASE;
            c_RELEASE: if (!r_done_s) w_state_next = c_IDLE;
            default:                  w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        tx_enable = (r_state == c_SEND);
        busy      = (r_state != c_IDLE);
        tx_data   = r_tx_data;
    end

`ifdef UART_TX_QUEUE_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (write_enable && full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_queue
// Purpose  : Randomized scoreboard bench for uart_tx_queue with a transmitter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    write_data;
    logic          write_enable;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    tx_data;
    logic          tx_enable;
    logic          tx_done;
    logic          busy;
`ifdef UART_TX_QUEUE_OVERFLOW_FLAG_EN
    logic          overflow;
    logic          m_ovf;
`endif

    int checks = 0;
    int errors = 0;

    // Transmitter model state
    logic tx_model_done = 1'b0;
    logic tx_force      = 1'b0;
    logic tx_stall      = 1'b0;
    int   tx_ph         = 0;
    int   tx_cnt        = 0;

    // Reference model / scoreboard state
    logic [7:0] exp_q[$];
    logic       m_we = 1'b0;
    logic [7:0] m_wd = 8'h00;
    logic       prev_en   = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         rises     = 0;
    int         pushes    = 0;
    logic       track     = 1'b0;
    int         peak      = 0;
    logic       full_seen = 1'b0;

    assign tx_done = tx_model_done | tx_force;

    always #5 clock = ~clock;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .write_data   (write_data),
        .write_enable (write_enable),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .tx_data      (tx_data),
        .tx_enable    (tx_enable),
        .tx_done      (tx_done),
        .busy         (busy)
`ifdef UART_TX_QUEUE_OVERFLOW_FLAG_EN
        ,
        .overflow     (overflow)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Capture the write request exactly as the DUT sees it at the edge.
    always @(posedge clock) begin
        m_we <= write_enable;
        m_wd <= write_data;
    end

    // Transmitter: done rises 3 clocks after enable, held 2 clocks.
    always @(negedge clock) begin
        if (reset) begin
            tx_ph = 0; tx_cnt = 0; tx_model_done = 1'b0;
        end else begin
            case (tx_ph)
                0: if (tx_enable) begin tx_ph = 1; tx_cnt = 0; end
                1: if (!tx_stall) begin
                       tx_cnt++;
                       if (tx_cnt == 3) begin tx_model_done = 1'b1; tx_ph = 2; tx_cnt = 0; end
                   end
                2: begin
                       tx_cnt++;
                       if (tx_cnt == 2) begin tx_model_done = 1'b0; tx_ph = 3; end
                   end
                default: if (!tx_enable) tx_ph = 0;
            endcase
        end
    end

    // Monitor: one edge of history, model is a plain byte queue.
    always @(negedge clock) begin
        logic       push;
        logic       pop;
        logic [7:0] exp_b;
        if (reset) begin
            exp_q.delete();
            prev_en = 1'b0;
            prev_data = 8'h00;
`ifdef UART_TX_QUEUE_OVERFLOW_FLAG_EN
            m_ovf = 1'b0;
`endif
        end else begin
            push = m_we && (exp_q.size() < DEPTH);
            pop  = tx_enable && !prev_en;
`ifdef UART_TX_QUEUE_OVERFLOW_FLAG_EN
            if (m_we && exp_q.size() >= DEPTH) m_ovf = 1'b1;
            chk("overflow flag", 32'(overflow), 32'(m_ovf));
`endif
            if (pop) begin
                rises++;
                if (exp_q.size() == 0) begin
                    chk("underflow pop", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("tx_data order", 32'(tx_data), 32'(exp_b));
                end
            end else begin
                chk("tx_data stable", 32'(tx_data), 32'(prev_data));
            end
            if (push) begin
                exp_q.push_back(m_wd);
                pushes++;
            end
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(exp_q.size() == 0));
            if (tx_enable) chk("busy while enabled", 32'(busy), 32'd1);
            if (track) begin
                if (int'(count) > peak) peak = int'(count);
                if (full) full_seen = 1'b1;
            end
            prev_en   = tx_enable;
            prev_data = tx_data;
        end
    end

    task automatic wr(input logic [7:0] d);
        write_data   = d;
        write_enable = 1'b1;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy && !tx_enable && tx_ph == 0 && !tx_done) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk({name, " drain within budget"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_enable(input string name);
        int n = 0;
        while (!tx_enable && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk({name, " enable within budget"}, 32'(n < 100), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int p0;
        reset        = 1'b1;
        write_enable = 1'b0;
        write_data   = 8'h00;
        #1;
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset tx_enable", 32'(tx_enable), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'h00);
        chk("reset busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);

        // Single byte: enable appears after write edge plus pop edge
        wr(8'hAB);
        #1;
        chk("latency write edge enable", 32'(tx_enable), 32'd0);
        chk("latency write edge count", 32'(count), 32'd1);
        @(negedge clock);
        #1;
        chk("latency pop edge enable", 32'(tx_enable), 32'd1);
        chk("latency pop edge data", 32'(tx_data), 32'hAB);
        wait_idle("single");
        chk("single empty", 32'(empty), 32'd1);
        chk("single one pulse", 32'(rises), 32'd1);

        // Burst with transmitter stalled: first byte pops, peak is DEPTH-1
        tx_stall = 1'b1;
        track = 1'b1; peak = 0; full_seen = 1'b0;
        r0 = rises;
        for (int i = 1; i <= 16; i++) wr(8'(i));
        repeat (2) @(negedge clock);
        #1 track = 1'b0;
        chk("burst peak count", 32'(peak), 32'd15);
        chk("burst full never", 32'(full_seen), 32'd0);
        tx_stall = 1'b0;
        wait_idle("burst");
        chk("burst pulse count", 32'(rises - r0), 32'd16);

        // done held high while idle blocks the pop
        tx_force = 1'b1;
        repeat (3) @(negedge clock);
        wr(8'h5A);
        repeat (6) @(negedge clock);
        #1;
        chk("done blocks pop enable", 32'(tx_enable), 32'd0);
        chk("done blocks pop count", 32'(count), 32'd1);
        tx_force = 1'b0;
        wait_idle("done block");

        // Overflow: fill while stalled, extra write dropped
        tx_stall = 1'b1;
        for (int i = 0; i < 17; i++) wr(8'h20 + 8'(i));
        #1;
        chk("fill count", 32'(count), 32'd16);
        chk("fill full", 32'(full), 32'd1);
        wr(8'hFF);
        #1;
        chk("overflow count held", 32'(count), 32'd16);
        tx_stall = 1'b0;
        wait_idle("overflow");
`ifdef UART_TX_QUEUE_OVERFLOW_FLAG_EN
        chk("overflow sticky", 32'(overflow), 32'd1);
`endif

        // Random traffic with simultaneous push/pop across pointer wrap
        r0 = rises; p0 = pushes;
        for (int i = 0; i < 400; i++) begin
            write_enable = ($urandom_range(0, 3) != 0);
            write_data   = 8'($urandom);
            @(negedge clock);
        end
        write_enable = 1'b0;
        wait_idle("random");
        chk("random pulses match pushes", 32'(rises - r0), 32'(pushes - p0));

        // Reset in the middle of a transfer
        tx_stall = 1'b1;
        wr(8'h11); wr(8'h22); wr(8'h33);
        wait_enable("pre-reset");
        #2 reset = 1'b1;
        #1;
        chk("mid reset tx_enable", 32'(tx_enable), 32'd0);
        chk("mid reset count", 32'(count), 32'd0);
        chk("mid reset empty", 32'(empty), 32'd1);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset tx_data", 32'(tx_data), 32'h00);
`ifdef UART_TX_QUEUE_OVERFLOW_FLAG_EN
        chk("mid reset overflow", 32'(overflow), 32'd0);
`endif
        tx_stall = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        r0 = rises;
        repeat (20) @(negedge clock);
        #1;
        chk("post reset no pulse", 32'(rises - r0), 32'd0);
        chk("post reset enable low", 32'(tx_enable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
